fb_pixel_writer: RTL and testbench

- Avalon-MM write initiator that feeds the 1-bpp framebuffer slave of the VGA display peripheral.
- Accepts a serial pixel stream (one bit per pixel, raster order) with a valid/ready handshake.
- Packs every 32 pixels into one word and issues word writes at consecutive framebuffer addresses.
- Packing is the exact inverse of the display scan-out: pixel n goes to word n/32, bit n%32 (bit 0 = leftmost pixel).

---
 rtl/fb_pixel_writer.sv | 149 ++++++++++++++
 tb/tb_fb_pixel_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// Packs a raster 1-bpp pixel stream into 32-bit words and writes them to the framebuffer over Avalon-MM.
// Latency: the word completed by the 32nd pixel at cycle t is presented (avm_write=1) at t+1.
// Backpressure: pix_ready drops only when a word completes while the hold register cannot drain.
// Optional FB_WRITER_CLEAR_EN adds a full-frame fill (STREAM -> CLEAR_WAIT -> CLEAR -> STREAM).
module fb_pixel_writer #(
    parameter int FB_WORDS  = 9600,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_data,
    input  logic              pix_sof,
    output logic [ADDR_W-1:0] avm_address,
    output logic [31:0]       avm_writedata,
    output logic              avm_write,
    output logic              avm_chipselect,
    input  logic              avm_waitrequest,
`ifdef FB_WRITER_CLEAR_EN
    input  logic              clear_req,
    input  logic              clear_val,
`endif
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FB_WORDS - 1);

    logic [31:0]       acc;
    logic [4:0]        cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              pending;
    logic              accept;
    logic              stall;
    logic              beat;
    logic              word_done;
    logic [31:0]       word_dat;
    logic              load;
    logic [31:0]       load_dat;

    assign avm_write      = pending;
    assign avm_chipselect = pending;
    assign accept         = pending && !avm_waitrequest;
    assign frame_done     = accept && (avm_address == LAST_ADDR);
    assign next_addr      = (wr_addr == LAST_ADDR) ? FIRST_ADDR : wr_addr + ADDR_W'(1);

    // A word completes only if the hold register is free or draining this very cycle.
    assign stall     = pending && (cnt == 5'd31) && !accept;
    assign beat      = pix_valid && pix_ready;
    assign word_done = beat && !pix_sof && (cnt == 5'd31);
    assign word_dat  = acc | {pix_data, 31'b0};

`ifdef FB_WRITER_CLEAR_EN
    typedef enum logic [1:0] {
        ST_STREAM,
        ST_CLEAR_WAIT,
        ST_CLEAR
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   clr_val;
    logic   clr_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_STREAM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STREAM:     if (clear_req) state_nxt = ST_CLEAR_WAIT;
            ST_CLEAR_WAIT: if (!pending) state_nxt = ST_CLEAR;
            ST_CLEAR:      if (frame_done) state_nxt = ST_STREAM;
            default:       state_nxt = ST_STREAM;
        endcase
    end

    // Stop issuing once the last fill word sits in the hold register.
    assign clr_load  = (state == ST_CLEAR) && (!pending || (accept && avm_address != LAST_ADDR));
    assign pix_ready = (state == ST_STREAM) && !clear_req && !stall;
    assign load      = word_done || clr_load;
    assign load_dat  = clr_load ? {32{clr_val}} : word_dat;
`else
    assign pix_ready = !stall;
    assign load      = word_done;
    assign load_dat  = word_dat;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            cnt           <= '0;
            wr_addr       <= FIRST_ADDR;
            pending       <= 1'b0;
            avm_address   <= FIRST_ADDR;
            avm_writedata <= '0;
`ifdef FB_WRITER_CLEAR_EN
            clr_val       <= 1'b0;
`endif
        end else begin
            if (load) begin
                avm_writedata <= load_dat;
                avm_address   <= wr_addr;
                wr_addr       <= next_addr;
                pending       <= 1'b1;
            end else if (accept) begin
                pending <= 1'b0;
            end

            if (beat) begin
                if (pix_sof) begin
                    acc     <= {31'b0, pix_data};
                    cnt     <= 5'd1;
                    wr_addr <= FIRST_ADDR;
                end else if (cnt == 5'd31) begin
                    acc <= '0;
                    cnt <= 5'd0;
                end else begin
                    acc[cnt] <= pix_data;
                    cnt      <= cnt + 5'd1;
                end
            end

`ifdef FB_WRITER_CLEAR_EN
            if (state == ST_STREAM && clear_req) begin
                clr_val <= clear_val;
                acc     <= '0;
                cnt     <= 5'd0;
            end
            if (state == ST_CLEAR_WAIT && !pending) begin
                wr_addr <= FIRST_ADDR;
            end
            if (state == ST_CLEAR && frame_done) begin
                cnt     <= 5'd0;
                wr_addr <= FIRST_ADDR;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a 6-word frame so a full frame and wrap fit in a short run.
module tb_fb_pixel_writer;

    localparam int FBW = 6;
    localparam int AW  = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          pix_data = 1'b0;
    logic          pix_sof = 1'b0;
    logic [AW-1:0] avm_address;
    logic [31:0]   avm_writedata;
    logic          avm_write;
    logic          avm_chipselect;
    logic          avm_waitrequest = 1'b0;
    logic          frame_done;
`ifdef FB_WRITER_CLEAR_EN
    logic          clear_req = 1'b0;
    logic          clear_val = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            wc_q[$];
    int            fd_cnt = 0;
    logic [AW-1:0] fd_addr = '0;

    fb_pixel_writer #(.FB_WORDS(FBW), .BASE_ADDR(0), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_data        (pix_data),
        .pix_sof         (pix_sof),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_chipselect  (avm_chipselect),
        .avm_waitrequest (avm_waitrequest),
`ifdef FB_WRITER_CLEAR_EN
        .clear_req       (clear_req),
        .clear_val       (clear_val),
`endif
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted write, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && avm_write && !avm_waitrequest) begin
            wa_q.push_back(avm_address);
            wd_q.push_back(avm_writedata);
            wc_q.push_back(cyc);
        end
        if (!reset && frame_done) begin
            fd_cnt  = fd_cnt + 1;
            fd_addr = avm_address;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic d, input logic s);
        int b = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        @(negedge clk);
        while (!pix_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!pix_ready) check("pix_ready_timeout", {63'b0, pix_ready}, 64'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic sof_first);
        for (int i = 0; i < 32; i++) send(w[i], sof_first && (i == 0));
    endtask

    task automatic wait_writes(input int n, input string tag);
        int b = 0;
        while (wa_q.size() < n && b < 500) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        check(tag, 64'(wa_q.size()), 64'(n));
    endtask

    int q0;
    int fd0;
    int unstable;
    int stall_seen;
    int rdy_err;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_write", {63'b0, avm_write}, 64'd0);
        check("rst_cs", {63'b0, avm_chipselect}, 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_data", 64'(avm_writedata), 64'd0);
        check("rst_frame_done", {63'b0, frame_done}, 64'd0);
        check("rst_ready", {63'b0, pix_ready}, 64'd1);

        // Alternating 1,0,1,0 word with latency check
        q0 = wa_q.size();
        for (int i = 0; i < 31; i++) send(((i % 2) == 0), (i == 0));
        @(negedge clk);
        check("alt_no_write_early", {63'b0, avm_write}, 64'd0);
        @(posedge clk);
        #1;
        send(1'b0, 1'b0);
        @(negedge clk);
        check("alt_write_t1", {63'b0, avm_write}, 64'd1);
        check("alt_cs_t1", {63'b0, avm_chipselect}, 64'd1);
        check("alt_addr_t1", 64'(avm_address), 64'd0);
        check("alt_data_t1", 64'(avm_writedata), 64'h55555555);
        wait_writes(q0 + 1, "alt_count");
        check("alt_q_data", 64'(wd_q[q0]), 64'h55555555);

        // Waitrequest held for 40 cycles with continuous streaming
        q0 = wa_q.size();
        unstable = 0;
        stall_seen = 0;
        avm_waitrequest = 1'b1;
        fork
            begin
                send_word(32'hF0F0F0F0, 1'b1);
                send_word(32'hFFFFFFFF, 1'b0);
            end
            begin
                int b = 0;
                @(negedge clk);
                while (!avm_write && b < 200) begin
                    @(negedge clk);
                    b++;
                end
                check("wr_wait_write", {63'b0, avm_write}, 64'd1);
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (avm_address != 0 || avm_writedata != 32'hF0F0F0F0 || !avm_write) unstable++;
                    if (!pix_ready) stall_seen = 1;
                end
                @(posedge clk);
                #1 avm_waitrequest = 1'b0;
            end
        join
        wait_writes(q0 + 2, "wr_count");
        check("wr_stable", 64'(unstable), 64'd0);
        check("wr_stall_seen", 64'(stall_seen), 64'd1);
        check("wr_w0_addr", 64'(wa_q[q0]), 64'd0);
        check("wr_w0_data", 64'(wd_q[q0]), 64'hF0F0F0F0);
        check("wr_w1_addr", 64'(wa_q[q0+1]), 64'd1);
        check("wr_w1_data", 64'(wd_q[q0+1]), 64'hFFFFFFFF);
        check("wr_b2b", 64'(wc_q[q0+1] - wc_q[q0]), 64'd1);

        // Partial word discarded by sof
        q0 = wa_q.size();
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        for (int i = 0; i < 31; i++) send(1'b0, 1'b0);
        wait_writes(q0 + 1, "sof_count");
        check("sof_addr", 64'(wa_q[q0]), 64'd0);
        check("sof_data", 64'(wd_q[q0]), 64'h00000001);

        // Full frame, wrap without sof
        q0 = wa_q.size();
        fd0 = fd_cnt;
        send_word(32'hFFFFFFFF, 1'b1);
        for (int w = 1; w < FBW; w++) send_word(32'hFFFFFFFF, 1'b0);
        send_word(32'h12345678, 1'b0);
        wait_writes(q0 + FBW + 1, "frame_count");
        for (int w = 0; w < FBW; w++) begin
            check($sformatf("frame_addr%0d", w), 64'(wa_q[q0+w]), 64'(w));
            check($sformatf("frame_data%0d", w), 64'(wd_q[q0+w]), 64'hFFFFFFFF);
        end
        check("frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);
        check("frame_done_addr", 64'(fd_addr), 64'(FBW - 1));
        check("wrap_addr", 64'(wa_q[q0+FBW]), 64'd0);
        check("wrap_data", 64'(wd_q[q0+FBW]), 64'h12345678);

        // Reset while a write is stalled
        avm_waitrequest = 1'b1;
        send_word(32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        check("mid_rst_pre_write", {63'b0, avm_write}, 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_write", {63'b0, avm_write}, 64'd0);
        check("mid_rst_addr", 64'(avm_address), 64'd0);
        check("mid_rst_ready", {63'b0, pix_ready}, 64'd1);
        q0 = wa_q.size();
        avm_waitrequest = 1'b0;
        send_word(32'hAAAAAAAA, 1'b1);
        wait_writes(q0 + 1, "mid_rst_count");
        check("mid_rst_new_addr", 64'(wa_q[q0]), 64'd0);
        check("mid_rst_new_data", 64'(wd_q[q0]), 64'hAAAAAAAA);

`ifdef FB_WRITER_CLEAR_EN
        // Full-frame fill with zeros
        q0 = wa_q.size();
        fd0 = fd_cnt;
        rdy_err = 0;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        clear_val = 1'b0;
        clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        begin
            int b = 0;
            while (fd_cnt == fd0 && b < 300) begin
                @(negedge clk);
                if (pix_ready && fd_cnt == fd0) rdy_err++;
                b++;
            end
        end
        check("clr_ready_low", 64'(rdy_err), 64'd0);
        check("clr_frame_done", 64'(fd_cnt - fd0), 64'd1);
        wait_writes(q0 + FBW, "clr_count");
        for (int w = 0; w < FBW; w++) begin
            check($sformatf("clr_addr%0d", w), 64'(wa_q[q0+w]), 64'(w));
            check($sformatf("clr_data%0d", w), 64'(wd_q[q0+w]), 64'h00000000);
        end
        check("clr_ready_after", {63'b0, pix_ready}, 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
